// File: rtl/secuenciador_pkg.sv
// secuenciador_pkg: shared states and constants for the tube row sequencer
package secuenciador_pkg;
  typedef enum logic [2:0] {IDLE, CARGA, ESPERA, RUN, FIN} estado_t;
  localparam int ANCHO_HILERA = 5;
  localparam int PUNTO_FINAL = 480;
  localparam int PERIODO_MIN = 1;
endpackage

// File: rtl/rom_patrones.sv
// rom_patrones: song row masks, registered read with one cycle of latency
module rom_patrones
  import secuenciador_pkg::*;
#(
  parameter int NUM_FILAS = 32
) (
  input  logic                          clk,
  input  logic [$clog2(NUM_FILAS)-1:0]  dir_i,
  output logic [ANCHO_HILERA-1:0]       dato_o
);
  localparam int W = $clog2(NUM_FILAS);
  logic [ANCHO_HILERA-1:0] dato_d;
  logic [2:0] bajo;
  assign bajo = 3'(dir_i);
  always_comb begin
    dato_d = 5'b00001;
    case (dir_i)
      W'(NUM_FILAS - 1): dato_d = 5'b11111;
      W'(0):             dato_d = 5'b00001;
      W'(1):             dato_d = 5'b00010;
      default:
        case (bajo)
          3'd0:    dato_d = 5'b00011;
          3'd1:    dato_d = 5'b00110;
          3'd2:    dato_d = 5'b00100;
          3'd3:    dato_d = 5'b01000;
          3'd4:    dato_d = 5'b10000;
          3'd5:    dato_d = 5'b00101;
          3'd6:    dato_d = 5'b01010;
          default: dato_d = 5'b10001;
        endcase
    endcase
  end
  always_ff @(posedge clk) dato_o <= dato_d;
endmodule

// File: rtl/secuenciador_hileras.sv
// secuenciador_hileras: walks the song pattern, loads each row into the tube and paces its scroll.
// Define SECUENCIADOR_ACEL_EN to shorten the scroll period by one frame every 8 rows.
module secuenciador_hileras
  import secuenciador_pkg::*;
#(
  parameter int NUM_FILAS   = 32,
  parameter int PERIODO_INI = 4,
  parameter int POS_INICIAL = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pausa,
  input  logic                          frame_tick,
  input  logic                          fila_fin,
  output logic                          enable,
  output logic                          contar,
  output logic [9:0]                    posicion_y,
  output logic [ANCHO_HILERA-1:0]       cubos_hilera,
  output logic [$clog2(NUM_FILAS)-1:0]  indice,
  output logic                          activo,
  output logic                          cancion_fin
);
  localparam int W = $clog2(NUM_FILAS);
  localparam logic [W-1:0] ULTIMA = W'(NUM_FILAS - 1);
  estado_t estado_q, estado_d;
  logic [W-1:0] indice_q, indice_d;
  logic [3:0] cnt_q, cnt_d, periodo_q, periodo_d;
  logic [ANCHO_HILERA-1:0] cubos_q, cubos_d, dato_rom;
  logic enable_q, enable_d, contar_q, contar_d, activo_q, fin_q;
`ifdef SECUENCIADOR_ACEL_EN
  logic [2:0] sig_bajo;
  assign sig_bajo = 3'(indice_q) + 3'd1;
`endif
  // The ROM is addressed with the next index so its data is ready while in CARGA.
  rom_patrones #(.NUM_FILAS(NUM_FILAS)) u_rom (
    .clk    (clk),
    .dir_i  (indice_d),
    .dato_o (dato_rom)
  );
  always_comb begin
    estado_d  = estado_q;
    indice_d  = indice_q;
    cnt_d     = cnt_q;
    periodo_d = periodo_q;
    cubos_d   = cubos_q;
    enable_d  = 1'b0;
    contar_d  = 1'b0;
    case (estado_q)
      IDLE, FIN:
        if (start) begin
          estado_d  = CARGA;
          indice_d  = '0;
          periodo_d = 4'(PERIODO_INI);
        end
      CARGA: begin
        estado_d = ESPERA;
        cubos_d  = dato_rom;
        enable_d = 1'b1;
        cnt_d    = '0;
      end
      ESPERA: estado_d = RUN;
      RUN:
        if (fila_fin) begin
          cnt_d = '0;
          if (indice_q == ULTIMA) begin
            estado_d = FIN;
            cubos_d  = '0;
          end else begin
            estado_d = CARGA;
            indice_d = indice_q + 1'b1;
`ifdef SECUENCIADOR_ACEL_EN
            if (sig_bajo == 3'd0 && periodo_q > 4'(PERIODO_MIN)) periodo_d = periodo_q - 4'd1;
`endif
          end
        end else if (frame_tick && !pausa) begin
          contar_d = cnt_q == periodo_q - 4'd1;
          cnt_d    = contar_d ? '0 : cnt_q + 4'd1;
        end
      default: estado_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      estado_q  <= IDLE;
      indice_q  <= '0;
      cnt_q     <= '0;
      periodo_q <= 4'(PERIODO_INI);
      cubos_q   <= '0;
      enable_q  <= 1'b0;
      contar_q  <= 1'b0;
      activo_q  <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      indice_q  <= indice_d;
      cnt_q     <= cnt_d;
      periodo_q <= periodo_d;
      cubos_q   <= cubos_d;
      enable_q  <= enable_d;
      contar_q  <= contar_d;
      activo_q  <= estado_d inside {CARGA, ESPERA, RUN};
      fin_q     <= estado_d == FIN;
    end
  assign enable       = enable_q;
  assign contar       = contar_q;
  assign posicion_y   = 10'(POS_INICIAL);
  assign cubos_hilera = cubos_q;
  assign indice       = indice_q;
  assign activo       = activo_q;
  assign cancion_fin  = fin_q;
endmodule

// File: tb/tb_secuenciador_hileras.sv
// tb_secuenciador_hileras: directed scoreboard bench for the row sequencer
module tb_secuenciador_hileras;
  localparam int NF = 32, PI = 4, PY = 37, W = $clog2(NF);
  typedef struct {int ciclo; logic [4:0] cubos; int idx; bit ver;} carga_t;
  logic clk = 0, reset = 0, start = 0, pausa = 0, frame_tick = 0, fila_fin = 0;
  logic enable, contar, activo, cancion_fin;
  logic [9:0] posicion_y;
  logic [4:0] cubos_hilera;
  logic [W-1:0] indice;
  int ciclo = 0, n_cmp = 0, n_err = 0, m_cnt = 0, m_per = PI, m_idx = 0;
  carga_t q_carga[$];
  int q_contar[$];
  carga_t e_mon;
  secuenciador_hileras #(.NUM_FILAS(NF), .PERIODO_INI(PI), .POS_INICIAL(PY)) dut (
    .clk(clk), .reset(reset), .start(start), .pausa(pausa), .frame_tick(frame_tick),
    .fila_fin(fila_fin), .enable(enable), .contar(contar), .posicion_y(posicion_y),
    .cubos_hilera(cubos_hilera), .indice(indice), .activo(activo), .cancion_fin(cancion_fin)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, ciclo);
    end
  endtask
  function automatic carga_t esperada(int n, int i);
    carga_t c;
    c.ciclo = n + 2;
    c.idx = i;
    c.cubos = i == NF - 1 ? 5'b11111 : i == 0 ? 5'b00001 : 5'b00010;
    c.ver = i == 0 || i == 1 || i == NF - 1;
    return c;
  endfunction
  always @(negedge clk) begin
    if (enable) begin
      chk("enable_expected", q_carga.size() != 0, 1);
      if (q_carga.size() != 0) begin
        e_mon = q_carga.pop_front();
        chk("enable_cycle", ciclo, e_mon.ciclo);
        chk("load_indice", indice, e_mon.idx);
        if (e_mon.ver) chk("load_cubos", cubos_hilera, e_mon.cubos);
        chk("enable_with_contar", contar, 0);
      end
    end
    if (contar) begin
      chk("contar_expected", q_contar.size() != 0, 1);
      if (q_contar.size() != 0) chk("contar_cycle", ciclo, q_contar.pop_front());
    end
  end
  task automatic ciclos(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic do_start(input bit acepta);
    start = 1;
    if (acepta) begin
      q_carga.push_back(esperada(ciclo, 0));
      m_idx = 0;
      m_per = PI;
      m_cnt = 0;
    end
    ciclos(1);
    start = 0;
  endtask
  task automatic do_tick(input bit en_run);
    frame_tick = 1;
    if (en_run && !pausa) begin
      m_cnt++;
      if (m_cnt == m_per) begin
        q_contar.push_back(ciclo + 1);
        m_cnt = 0;
      end
    end
    ciclos(1);
    frame_tick = 0;
  endtask
  task automatic do_fila(input bit con_tick);
    fila_fin = 1;
    frame_tick = con_tick;
    if (m_idx != NF - 1) begin
      m_idx++;
      q_carga.push_back(esperada(ciclo, m_idx));
`ifdef SECUENCIADOR_ACEL_EN
      if (m_idx % 8 == 0 && m_per > 1) m_per--;
`endif
    end
    m_cnt = 0;
    ciclos(1);
    fila_fin = 0;
    frame_tick = 0;
  endtask
  initial begin
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom_range(0, 1));
      pausa = 1'($urandom_range(0, 1));
      frame_tick = 1'($urandom_range(0, 1));
      fila_fin = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_enable", enable, 0);
      chk("rst_contar", contar, 0);
      chk("rst_cubos", cubos_hilera, 0);
      chk("rst_indice", indice, 0);
      chk("rst_activo", activo, 0);
      chk("rst_fin", cancion_fin, 0);
      chk("posicion_y", posicion_y, PY);
      @(posedge clk);
      #1;
    end
    {start, pausa, frame_tick, fila_fin} = '0;
    reset = 1;
    ciclos(5);
    chk("idle_activo", activo, 0);
    chk("idle_fin", cancion_fin, 0);
    do_start(1);
    chk("carga_activo", activo, 1);
    chk("carga_indice", indice, 0);
    ciclos(1);
    chk("load_enable", enable, 1);
    chk("load_cubos0", cubos_hilera, 5'b00001);
    ciclos(1);
    chk("enable_one_cycle", enable, 0);
    for (int i = 0; i < 6; i++) begin do_tick(1); ciclos(19); end
    pausa = 1;
    for (int i = 0; i < 3; i++) begin do_tick(1); ciclos(19); end
    pausa = 0;
    for (int i = 0; i < 2; i++) begin do_tick(1); ciclos(19); end
    do_start(0);
    ciclos(2);
    chk("start_ignored_indice", indice, 0);
    chk("start_ignored_activo", activo, 1);
    do_fila(1);
    chk("advance_indice", indice, 1);
    ciclos(2);
    chk("row1_cubos", cubos_hilera, 5'b00010);
    fila_fin = 1;
    q_carga.push_back(esperada(ciclo, 2));
    m_idx = 2;
    ciclos(1);
    chk("carga_after_fila", activo, 1);
    ciclos(1);
    fila_fin = 0;
    ciclos(1);
    chk("fila_ignored_carga", indice, 2);
    while (m_idx < NF - 1) begin
      repeat (4) begin do_tick(1); ciclos(1); end
      do_fila(0);
      ciclos(2);
    end
    chk("last_indice", indice, NF - 1);
    chk("last_cubos", cubos_hilera, 5'b11111);
    repeat (3) begin do_tick(1); ciclos(1); end
    do_fila(0);
    chk("fin_flag", cancion_fin, 1);
    chk("fin_cubos", cubos_hilera, 0);
    chk("fin_activo", activo, 0);
    do_tick(0);
    fila_fin = 1;
    ciclos(1);
    fila_fin = 0;
    chk("fin_holds", cancion_fin, 1);
    do_start(1);
    chk("restart_indice", indice, 0);
    chk("restart_fin", cancion_fin, 0);
    ciclos(2);
    chk("restart_cubos", cubos_hilera, 5'b00001);
    for (int i = 0; i < 6; i++) begin do_tick(1); ciclos(2); end
    reset = 0;
    #1;
    chk("abort_activo", activo, 0);
    chk("abort_indice", indice, 0);
    chk("abort_cubos", cubos_hilera, 0);
    m_cnt = 0;
    frame_tick = 1;
    ciclos(2);
    frame_tick = 0;
    reset = 1;
    ciclos(3);
    chk("after_abort_idle", activo, 0);
    chk("pending_loads", q_carga.size(), 0);
    chk("pending_contar", q_contar.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
